// File: rtl/data_cache_pkg.sv
// Shared types and address-field geometry for the
// direct-mapped write-through data cache.
package data_cache_pkg;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 32;
  localparam int DEF_LINES = 8;
  localparam int DEF_WORDS = 4;
  localparam int OFF_W     = 2;
  localparam int IDX_W     = 3;
  localparam int TAG_W     = 2;
  localparam int BLK_W     = DEF_WORDS * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_WAIT
  } state_t;

  function automatic logic [DATA_W-1:0] word_of(
    input logic [BLK_W-1:0] blk,
    input logic [OFF_W-1:0] off
  );
    return blk[{off, 5'd0} +: DATA_W];
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Processor and backing-memory signals of the data cache.
// master: processor/memory side, slave: the cache.
interface data_cache_if;
  import data_cache_pkg::*;

  logic              proc_cen;
  logic              proc_wen;
  logic              proc_oen;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic [DATA_W-1:0] proc_rdata;
  logic              proc_stall;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BLK_W-1:0]  mem_rdata;
  logic              mem_ready;

  modport master (
    output proc_cen, proc_wen, proc_oen,
    output proc_addr, proc_wdata,
    output mem_rdata, mem_ready,
    input  proc_rdata, proc_stall,
    input  mem_read, mem_write,
    input  mem_addr, mem_wdata
  );

  modport slave (
    input  proc_cen, proc_wen, proc_oen,
    input  proc_addr, proc_wdata,
    input  mem_rdata, mem_ready,
    output proc_rdata, proc_stall,
    output mem_read, mem_write,
    output mem_addr, mem_wdata
  );

endinterface

// File: rtl/data_cache_array.sv
// Tag, valid and data storage: one write port (fill or
// single-word update), combinational read at idx.
module data_cache_array
  import data_cache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IDX_W-1:0]        idx,
  input  logic                    fill,
  input  logic [TAG_W-1:0]        fill_tag,
  input  logic [WORDS*DATA_W-1:0] fill_blk,
  input  logic                    upd,
  input  logic [OFF_W-1:0]        upd_off,
  input  logic [DATA_W-1:0]       upd_word,
  output logic                    rd_valid,
  output logic [TAG_W-1:0]        rd_tag,
  output logic [WORDS*DATA_W-1:0] rd_blk
);

  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tags [LINES];
  logic [WORDS*DATA_W-1:0] data [LINES];

  always_ff @(posedge clk) begin
    if (!rst_n)
      valid <= '0;
    else if (fill)
      valid[idx] <= 1'b1;
  end

  // Contents are left stale on reset; valid gates them.
  always_ff @(posedge clk) begin
    if (fill) begin
      data[idx] <= fill_blk;
      tags[idx] <= fill_tag;
    end else if (upd) begin
      data[idx][{upd_off, 5'd0} +: DATA_W] <= upd_word;
    end
  end

  assign rd_valid = valid[idx];
  assign rd_tag   = tags[idx];
  assign rd_blk   = data[idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data
// cache with blocking miss handling.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input logic         clk,
  input logic         rst_n,
  data_cache_if.slave bus
);

  state_t state, nxt;

  logic [TAG_W-1:0]        tag;
  logic [IDX_W-1:0]        idx;
  logic [OFF_W-1:0]        off;
  logic                    rd, wr;
  logic                    rd_hit, rd_miss, hit;
  logic                    fill, upd;
  logic                    line_v;
  logic [TAG_W-1:0]        line_tag;
  logic [WORDS*DATA_W-1:0] line_blk;

  assign tag = bus.proc_addr[6:5];
  assign idx = bus.proc_addr[4:2];
  assign off = bus.proc_addr[1:0];

  // Write wins over read when both enables are low.
  assign wr = !bus.proc_cen && !bus.proc_wen;
  assign rd = !bus.proc_cen && bus.proc_wen
           && !bus.proc_oen;

  assign hit     = line_v && (line_tag == tag);
  assign rd_hit  = rd && hit;
  assign rd_miss = rd && !hit;

  data_cache_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (idx),
    .fill     (fill),
    .fill_tag (tag),
    .fill_blk (bus.mem_rdata),
    .upd      (upd),
    .upd_off  (off),
    .upd_word (bus.proc_wdata),
    .rd_valid (line_v),
    .rd_tag   (line_tag),
    .rd_blk   (line_blk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt            = state;
    fill           = 1'b0;
    upd            = 1'b0;
    bus.proc_stall = 1'b0;
    bus.proc_rdata = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    // Reset silences the memory side so a pending
    // request is dropped without a fill.
    if (!rst_n) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            wr: begin
              bus.proc_stall = 1'b1;
              nxt            = WR_WAIT;
            end
            rd_hit: begin
              bus.proc_rdata = word_of(line_blk, off);
            end
            rd_miss: begin
              bus.proc_stall = 1'b1;
              nxt            = RD_MISS;
            end
            default: ;
          endcase
        end
        RD_MISS: begin
          bus.mem_read   = 1'b1;
          bus.mem_addr   = {bus.proc_addr[6:2], 2'b00};
          bus.proc_stall = 1'b1;
          if (bus.mem_ready) begin
            fill           = 1'b1;
            bus.proc_stall = 1'b0;
            bus.proc_rdata = word_of(bus.mem_rdata, off);
            nxt            = IDLE;
          end
        end
        WR_WAIT: begin
          bus.mem_write  = 1'b1;
          bus.mem_addr   = bus.proc_addr;
          bus.mem_wdata  = bus.proc_wdata;
          bus.proc_stall = 1'b1;
          if (bus.mem_ready) begin
            upd            = hit;
            bus.proc_stall = 1'b0;
            nxt            = IDLE;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomized self-checking bench for data_cache against
// a line-level cache model and a word-array memory.
module tb_data_cache;
  import data_cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  data_cache_if bus ();

  data_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem [128];
  bit          ref_v   [8];
  logic [4:0]  ref_blk [8];
  logic [31:0] ref_d   [8][4];

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_idle();
    bus.proc_cen = 1'b1;
    bus.proc_wen = 1'b1;
    bus.proc_oen = 1'b1;
  endtask

  function automatic logic [127:0] blk_of(
    input logic [6:0] a
  );
    int b;
    b = {a[6:2], 2'b00};
    return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
  endfunction

  function automatic bit ref_hit(input logic [6:0] a);
    int ix;
    ix = a[4:2];
    return ref_v[ix] && (ref_blk[ix] == a[6:2]);
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 8; i++) ref_v[i] = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_stall"}, bus.proc_stall, 0);
    chk({tag, "_rdata"}, bus.proc_rdata, 0);
    chk({tag, "_mrd"}, bus.mem_read, 0);
    chk({tag, "_mwr"}, bus.mem_write, 0);
    chk({tag, "_maddr"}, bus.mem_addr, 0);
    chk({tag, "_mwdata"}, bus.mem_wdata, 0);
  endtask

  task automatic do_read(
    input logic [6:0] a,
    input int         lat
  );
    int ix;
    int b;
    ix = a[4:2];
    b  = {a[6:2], 2'b00};
    bus.proc_cen  = 1'b0;
    bus.proc_wen  = 1'b1;
    bus.proc_oen  = 1'b0;
    bus.proc_addr = a;
    #1;
    if (ref_hit(a)) begin
      chk("rd_hit_stall", bus.proc_stall, 0);
      chk("rd_hit_data", bus.proc_rdata,
          ref_d[ix][a[1:0]]);
      chk("rd_hit_mreq",
          bus.mem_read | bus.mem_write, 0);
      tick();
    end else begin
      chk("rd_miss_stall", bus.proc_stall, 1);
      chk("rd_miss_idle_mrd", bus.mem_read, 0);
      tick();
      for (int i = 0; i < lat; i++) begin
        chk("miss_mrd", bus.mem_read, 1);
        chk("miss_mwr", bus.mem_write, 0);
        chk("miss_addr", bus.mem_addr, b);
        chk("miss_stall", bus.proc_stall, 1);
        tick();
      end
      bus.mem_rdata = blk_of(a);
      bus.mem_ready = 1'b1;
      #1;
      chk("fill_stall", bus.proc_stall, 0);
      chk("fill_data", bus.proc_rdata, mem[a]);
      chk("fill_mwr", bus.mem_write, 0);
      tick();
      bus.mem_ready = 1'b0;
      ref_v[ix]   = 1'b1;
      ref_blk[ix] = a[6:2];
      for (int w = 0; w < 4; w++)
        ref_d[ix][w] = mem[b+w];
    end
    req_idle();
    #1;
    chk("after_rd_rdata", bus.proc_rdata, 0);
    chk("after_rd_stall", bus.proc_stall, 0);
  endtask

  task automatic do_write(
    input logic [6:0]  a,
    input logic [31:0] d,
    input int          lat
  );
    int ix;
    ix = a[4:2];
    bus.proc_cen   = 1'b0;
    bus.proc_wen   = 1'b0;
    bus.proc_oen   = 1'($urandom_range(0, 1));
    bus.proc_addr  = a;
    bus.proc_wdata = d;
    #1;
    chk("wr_stall", bus.proc_stall, 1);
    chk("wr_idle_mwr", bus.mem_write, 0);
    tick();
    for (int i = 0; i < lat; i++) begin
      chk("wr_mwr", bus.mem_write, 1);
      chk("wr_mrd", bus.mem_read, 0);
      chk("wr_addr", bus.mem_addr, a);
      chk("wr_wdata", bus.mem_wdata, d);
      chk("wr_wait_stall", bus.proc_stall, 1);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("wr_done_mwr", bus.mem_write, 1);
    chk("wr_done_stall", bus.proc_stall, 0);
    tick();
    bus.mem_ready = 1'b0;
    mem[a] = d;
    if (ref_hit(a)) ref_d[ix][a[1:0]] = d;
    req_idle();
    #1;
    chk("after_wr_stall", bus.proc_stall, 0);
  endtask

  initial begin
    req_idle();
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_rdata  = '0;
    bus.mem_ready  = 1'b0;
    ref_clear();
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[4] = 32'hAAAA_0000;
    mem[5] = 32'hBBBB_1111;
    mem[6] = 32'hCCCC_2222;
    mem[7] = 32'hDDDD_3333;

    rst_n = 1'b0;
    tick();
    tick();
    check_quiet("rst");
    rst_n = 1'b1;
    tick();
    check_quiet("post_rst");

    bus.mem_ready = 1'b1;
    #1;
    chk("idle_ready_mrd", bus.mem_read, 0);
    chk("idle_ready_stall", bus.proc_stall, 0);
    tick();
    bus.mem_ready = 1'b0;

    do_read(7'h05, 2);
    do_read(7'h06, 0);
    do_write(7'h06, 32'hDEAD_BEEF, 1);
    do_read(7'h06, 0);
    do_write(7'h45, 32'h1234_5678, 1);
    do_read(7'h45, 1);
    do_read(7'h25, 1);
    do_read(7'h05, 1);
    do_read(7'h25, 0);

    // Reset while a fill is outstanding.
    bus.proc_cen  = 1'b0;
    bus.proc_wen  = 1'b1;
    bus.proc_oen  = 1'b0;
    bus.proc_addr = 7'h05;
    tick();
    chk("abort_mrd", bus.mem_read, 1);
    req_idle();
    rst_n = 1'b0;
    #1;
    chk("abort_rst_mrd", bus.mem_read, 0);
    tick();
    rst_n = 1'b1;
    bus.mem_rdata = {4{32'hBAD0_BAD0}};
    bus.mem_ready = 1'b1;
    #1;
    chk("late_ready_mrd", bus.mem_read, 0);
    chk("late_ready_stall", bus.proc_stall, 0);
    tick();
    bus.mem_ready = 1'b0;
    ref_clear();
    do_read(7'h05, 1);
    do_read(7'h25, 0);

    for (int n = 0; n < 200; n++) begin
      logic [6:0] a;
      a = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 9) < 6)
        do_read(a, $urandom_range(0, 3));
      else
        do_write(a, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
